// File: rtl/channel_readout_arbiter.sv
// Channel readout arbiter: round-robin selection among per-channel FWFT
// FIFOs, whole-packet ownership, and a sticky header-mismatch flag.
module channel_readout_arbiter #(
  parameter int NUM_CHANNELS = 4,
  parameter int PACKET_LEN   = 17
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_MasterEnable,
  input  logic [NUM_CHANNELS-1:0]    i_FifoEmpty,
  input  logic [16*NUM_CHANNELS-1:0] i_FifoData,
  output logic [NUM_CHANNELS-1:0]    o_FifoRead,
  output logic [15:0]                o_Data,
  output logic                       o_Valid,
  input  logic                       i_Ready,
  output logic [NUM_CHANNELS-1:0]    o_Grant,
  output logic                       o_PacketDone,
  output logic                       o_HeaderErr
);

  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int CNT_W = $clog2(PACKET_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(PACKET_LEN - 1);

  typedef enum logic [1:0] {IDLE, ARB, XFER} state_t;

  state_t          state;
  logic [CH_W-1:0] grantIdx;
  logic [CH_W-1:0] searchPtr;
  logic [CH_W-1:0] nextIdx;
  logic [CH_W:0]   cand;
  logic [CNT_W-1:0] wordCnt;
  logic            anyReq;
  logic            inXfer;
  logic            xferFire;
  logic            headerBad;

  assign anyReq    = |(~i_FifoEmpty);
  assign inXfer    = (state == XFER);
  assign xferFire  = o_Valid & i_Ready;
  assign headerBad = xferFire && (wordCnt == '0) && (o_Data[7:0] != 8'(grantIdx));

  // Round-robin search: the lowest offset from searchPtr with data wins,
  // so the loop runs backwards and the last hit is the nearest one.
  always_comb begin
    nextIdx = '0;
    cand    = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      cand = {1'b0, searchPtr} + (CH_W+1)'(i);
      if (cand >= (CH_W+1)'(NUM_CHANNELS))
        cand = cand - (CH_W+1)'(NUM_CHANNELS);
      if (!i_FifoEmpty[cand[CH_W-1:0]])
        nextIdx = cand[CH_W-1:0];
    end
  end

  // Output word is the granted channel's FIFO head, passed straight through.
  always_comb begin
    o_Data = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (grantIdx == CH_W'(k))
        o_Data = i_FifoData[16*k +: 16];
    end
  end

  // Handshake side: valid follows the granted FIFO, pop only on an accepted word.
  always_comb begin
    o_Valid      = inXfer & ~i_FifoEmpty[grantIdx];
    o_FifoRead   = (o_Valid & i_Ready) ? o_Grant : '0;
    o_PacketDone = o_Valid & i_Ready & (wordCnt == LAST_WORD);
  end

  // Control FSM: arbitration, packet word counting, sticky header error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grantIdx    <= '0;
      searchPtr   <= '0;
      wordCnt     <= '0;
      o_Grant     <= '0;
      o_HeaderErr <= 1'b0;
    end else begin
      if (headerBad)
        o_HeaderErr <= 1'b1;
      case (state)
        IDLE: begin
          if (i_MasterEnable && anyReq)
            state <= ARB;
        end
        ARB: begin
          if (anyReq) begin
            grantIdx  <= nextIdx;
            o_Grant   <= NUM_CHANNELS'(1) << nextIdx;
            searchPtr <= (nextIdx == CH_W'(NUM_CHANNELS - 1)) ? '0 : nextIdx + CH_W'(1);
            wordCnt   <= '0;
            state     <= XFER;
          end else begin
            state <= IDLE;
          end
        end
        XFER: begin
          // Ownership is released only after the final word of the packet.
          if (xferFire) begin
            if (wordCnt == LAST_WORD) begin
              wordCnt <= '0;
              o_Grant <= '0;
              state   <= i_MasterEnable ? ARB : IDLE;
            end else begin
              wordCnt <= wordCnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_channel_readout_arbiter.sv
// Bench for channel_readout_arbiter: queue-based FIFO model, directed
// scenarios plus a randomized run against a packet-level reference model.
module tb_channel_readout_arbiter;

  localparam int N  = 4;
  localparam int PL = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset = 1'b1;
  logic           enable = 1'b0;
  logic           ready = 1'b0;
  logic [N-1:0]   fifoEmpty;
  logic [16*N-1:0] fifoData;
  logic [N-1:0]   fifoRead;
  logic [15:0]    dataOut;
  logic           valid;
  logic [N-1:0]   grant;
  logic           pktDone;
  logic           hdrErr;

  int tests = 0;
  int fails = 0;

  logic [15:0] q [N][$];
  logic [N-1:0] stallMask = '0;

  logic [N-1:0]    cGrant, cRead, cEmpty;
  logic [15:0]     cData;
  logic            cValid, cDone, cErr;
  logic [16*N-1:0] cFifoData;

  channel_readout_arbiter #(.NUM_CHANNELS(N), .PACKET_LEN(PL)) dut (
    .clk(clk), .reset(reset), .i_MasterEnable(enable),
    .i_FifoEmpty(fifoEmpty), .i_FifoData(fifoData), .o_FifoRead(fifoRead),
    .o_Data(dataOut), .o_Valid(valid), .i_Ready(ready), .o_Grant(grant),
    .o_PacketDone(pktDone), .o_HeaderErr(hdrErr)
  );

  // One clock: present FIFO heads, sample outputs mid-cycle, pop on the edge.
  task automatic tick();
    for (int k = 0; k < N; k++) begin
      fifoEmpty[k] = (q[k].size() == 0) || stallMask[k];
      fifoData[16*k +: 16] = (q[k].size() > 0) ? q[k][0] : 16'h0000;
    end
    #1;
    cGrant = grant; cRead = fifoRead; cData = dataOut; cValid = valid;
    cDone = pktDone; cErr = hdrErr; cEmpty = fifoEmpty; cFifoData = fifoData;
    @(posedge clk);
    for (int k = 0; k < N; k++)
      if (cRead[k] && q[k].size() > 0) void'(q[k].pop_front());
    @(negedge clk);
  endtask

  task automatic pushPacket(input int ch, input logic [15:0] hdr);
    q[ch].push_back(hdr);
    for (int i = 0; i < PL - 1; i++) q[ch].push_back(16'($urandom));
  endtask

  task automatic clearAll();
    for (int k = 0; k < N; k++) q[k].delete();
    stallMask = '0;
  endtask

  task automatic doReset();
    clearAll();
    reset = 1'b1; enable = 1'b0; ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clearAll();
    pushPacket(0, 16'h0000);
    enable = 1'b1; ready = 1'b1; reset = 1'b1;
    tick(); tick();
    tests++; if (cGrant !== '0) begin fails++; $display("FAIL reset_grant: got %b want 0000", cGrant); end
    tests++; if (cValid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", cValid); end
    tests++; if (cRead !== '0) begin fails++; $display("FAIL reset_read: got %b want 0000", cRead); end
    tests++; if (cDone !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", cDone); end
    tests++; if (cErr !== 1'b0) begin fails++; $display("FAIL reset_hdrerr: got %b want 0", cErr); end
    reset = 1'b0;
    clearAll();
  endtask

  task automatic test_single_ch0();
    logic [15:0] words [$];
    int n = 0, firstAt = -1, doneCnt = 0, doneAt = -1, gaps = 0;
    doReset();
    pushPacket(0, 16'h0000);
    words = q[0];
    enable = 1'b1; ready = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      tick();
      if (cDone) begin doneCnt++; doneAt = n + 1; end
      if (cRead != '0) begin
        if (firstAt < 0) firstAt = cyc;
        else if (cyc != firstAt + n) gaps++;
        tests++; if (cRead !== 4'b0001 || cGrant !== 4'b0001) begin
          fails++; $display("FAIL single_owner: read %b grant %b want 0001", cRead, cGrant); end
        tests++; if (n < PL && cData !== words[n]) begin
          fails++; $display("FAIL single_data[%0d]: got %h want %h", n, cData, words[n]); end
        n++;
      end
    end
    tests++; if (firstAt !== 2) begin fails++; $display("FAIL single_latency: got %0d want 2", firstAt); end
    tests++; if (n !== PL) begin fails++; $display("FAIL single_count: got %0d want %0d", n, PL); end
    tests++; if (gaps !== 0) begin fails++; $display("FAIL single_consecutive: got %0d gaps want 0", gaps); end
    tests++; if (doneCnt !== 1 || doneAt !== PL) begin
      fails++; $display("FAIL single_done: pulses %0d at word %0d want 1 at %0d", doneCnt, doneAt, PL); end
    tests++; if (cGrant !== '0 || cValid !== 1'b0) begin
      fails++; $display("FAIL single_after: grant %b valid %b want 0000 0", cGrant, cValid); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] order [$];
    logic [N-1:0] expOrder [4];
    logic [N-1:0] owner = '0;
    int perPkt = 0;
    expOrder[0] = 4'b0010; expOrder[1] = 4'b1000; expOrder[2] = 4'b0010; expOrder[3] = 4'b1000;
    doReset();
    pushPacket(1, 16'h0001); pushPacket(1, 16'h0001);
    pushPacket(3, 16'h0003); pushPacket(3, 16'h0003);
    enable = 1'b1; ready = 1'b1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      tick();
      if (cRead != '0) begin
        if (perPkt == 0) owner = cGrant;
        tests++; if (cGrant !== owner || cRead !== owner) begin
          fails++; $display("FAIL rr_hold: grant %b read %b want %b", cGrant, cRead, owner); end
        perPkt++;
        if (cDone) begin
          tests++; if (perPkt !== PL) begin fails++; $display("FAIL rr_pktlen: got %0d want %0d", perPkt, PL); end
          order.push_back(owner);
          perPkt = 0;
        end
      end
    end
    tests++; if (order.size() !== 4) begin fails++; $display("FAIL rr_npkts: got %0d want 4", order.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < order.size()) begin
        tests++; if (order[i] !== expOrder[i]) begin
          fails++; $display("FAIL rr_order[%0d]: got %b want %b", i, order[i], expOrder[i]); end
      end
    end
  endtask

  task automatic test_ready_toggle();
    logic [15:0] words [$];
    logic [15:0] held = '0;
    int n = 0, doneCnt = 0;
    bit holdPending = 0;
    doReset();
    pushPacket(0, 16'h0000);
    words = q[0];
    enable = 1'b1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      ready = (cyc % 2 == 0);
      tick();
      if (cDone) doneCnt++;
      if (!ready) begin
        tests++; if (cRead !== '0) begin fails++; $display("FAIL toggle_pop_stalled: got %b want 0000", cRead); end
      end
      if (holdPending && cValid) begin
        tests++; if (cData !== held) begin fails++; $display("FAIL toggle_stable: got %h want %h", cData, held); end
      end
      holdPending = 0;
      if (cValid && !ready) begin held = cData; holdPending = 1; end
      if (cRead != '0) begin
        tests++; if (n < PL && cData !== words[n]) begin
          fails++; $display("FAIL toggle_data[%0d]: got %h want %h", n, cData, words[n]); end
        n++;
      end
    end
    tests++; if (n !== PL) begin fails++; $display("FAIL toggle_count: got %0d want %0d", n, PL); end
    tests++; if (doneCnt !== 1) begin fails++; $display("FAIL toggle_done: got %0d want 1", doneCnt); end
  endtask

  task automatic test_stall();
    logic [15:0] words [$];
    int n = 0, stallLeft = 0, doneCnt = 0;
    bit stallDone = 0, expectResume = 0;
    doReset();
    pushPacket(2, 16'h0002);
    words = q[2];
    enable = 1'b1; ready = 1'b1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (n == 5 && !stallDone) begin stallLeft = 10; stallDone = 1; end
      stallMask = (stallLeft > 0) ? 4'b0100 : 4'b0000;
      tick();
      if (cDone) doneCnt++;
      if (stallLeft > 0) begin
        tests++; if (cValid !== 1'b0 || cRead !== '0 || cGrant !== 4'b0100) begin
          fails++; $display("FAIL stall_hold: valid %b read %b grant %b want 0 0000 0100", cValid, cRead, cGrant); end
        stallLeft--;
        if (stallLeft == 0) expectResume = 1;
      end else begin
        if (expectResume) begin
          tests++; if (cRead !== 4'b0100 || cData !== words[5]) begin
            fails++; $display("FAIL stall_resume: read %b data %h want 0100 %h", cRead, cData, words[5]); end
          expectResume = 0;
        end
        if (cRead != '0) begin
          tests++; if (cGrant !== 4'b0100 || (n < PL && cData !== words[n])) begin
            fails++; $display("FAIL stall_data[%0d]: grant %b data %h", n, cGrant, cData); end
          n++;
        end
      end
    end
    stallMask = '0;
    tests++; if (n !== PL || doneCnt !== 1) begin
      fails++; $display("FAIL stall_count: words %0d done %0d want %0d 1", n, doneCnt, PL); end
  endtask

  task automatic test_header_err();
    int zeros = 0;
    bit seen = 0;
    doReset();
    pushPacket(2, 16'h0005);
    enable = 1'b1; ready = 1'b1;
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      tick();
      if (cRead != '0) seen = 1;
    end
    tests++; if (!seen) begin fails++; $display("FAIL hdr_first_word: got none want one within 10 cycles"); end
    tests++; if (cErr !== 1'b0) begin fails++; $display("FAIL hdr_before: got %b want 0", cErr); end
    tick();
    tests++; if (cErr !== 1'b1) begin fails++; $display("FAIL hdr_set: got %b want 1", cErr); end
    for (int cyc = 0; cyc < 40; cyc++) begin
      tick();
      if (cErr !== 1'b1) zeros++;
    end
    tests++; if (zeros !== 0) begin fails++; $display("FAIL hdr_sticky: got %0d cycles low want 0", zeros); end
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    tests++; if (cErr !== 1'b0) begin fails++; $display("FAIL hdr_cleared: got %b want 0", cErr); end
  endtask

  task automatic test_reset_mid();
    int n = 0, sizeAfter;
    bit seen = 0;
    doReset();
    pushPacket(1, 16'h0001);
    enable = 1'b1; ready = 1'b1;
    for (int cyc = 0; cyc < 30 && n < 8; cyc++) begin
      tick();
      if (cRead != '0) n++;
    end
    tests++; if (n !== 8) begin fails++; $display("FAIL rstmid_reach: got %0d words want 8", n); end
    pushPacket(0, 16'h0000);
    pushPacket(2, 16'h0002);
    reset = 1'b1;
    tick();
    sizeAfter = q[1].size();
    tick();
    tests++; if (cGrant !== '0 || cRead !== '0 || cValid !== 1'b0) begin
      fails++; $display("FAIL rstmid_abort: grant %b read %b valid %b want 0000 0000 0", cGrant, cRead, cValid); end
    tick();
    tests++; if (q[1].size() !== sizeAfter) begin
      fails++; $display("FAIL rstmid_nopop: got %0d left want %0d", q[1].size(), sizeAfter); end
    reset = 1'b0;
    q[1].delete();
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      tick();
      if (cRead != '0) begin
        seen = 1;
        tests++; if (cGrant !== 4'b0001) begin fails++; $display("FAIL rstmid_restart: got %b want 0001", cGrant); end
      end
    end
    tests++; if (!seen) begin fails++; $display("FAIL rstmid_timeout: got no transfer want one within 20 cycles"); end
  endtask

  // Packet-level reference: first transfer of a packet picks the nearest
  // channel with data from the rotating pointer; the owner then supplies
  // exactly PL words in queue order.
  task automatic test_random(input int rounds);
    for (int r = 0; r < rounds; r++) begin
      int total = 0, mPtr = 0, mOwner = 0, mCount = 0, bad = 0;
      bit inPkt = 0, finished = 0, xfer;
      logic [N-1:0] expRead, ownerHot;
      doReset();
      for (int k = 0; k < N; k++) begin
        int np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) pushPacket(k, {8'($urandom), 8'(k)});
        total += np;
      end
      if (total == 0) pushPacket(0, 16'h0000);
      enable = 1'b1;
      for (int cyc = 0; cyc < 8000 && !finished; cyc++) begin
        ready = ($urandom_range(0, 9) < 7);
        stallMask = (inPkt && mCount > 0 && $urandom_range(0, 4) == 0) ? (N'(1) << mOwner) : '0;
        tick();
        tests++; if (!$onehot0(cGrant)) begin fails++; $display("FAIL rnd_onehot: got %b want one-hot or zero", cGrant); end
        if (cGrant == '0) begin
          tests++; if (cValid !== 1'b0) begin fails++; $display("FAIL rnd_valid_nogrant: got %b want 0", cValid); end
        end
        xfer = cValid && ready;
        if (xfer && !inPkt) begin
          for (int i = N - 1; i >= 0; i--)
            if (!cEmpty[(mPtr + i) % N]) mOwner = (mPtr + i) % N;
          mPtr = (mOwner + 1) % N;
          inPkt = 1; mCount = 0;
        end
        ownerHot = N'(1) << mOwner;
        if (inPkt) begin
          tests++; if (cValid !== !cEmpty[mOwner]) begin
            fails++; $display("FAIL rnd_valid: got %b want %b", cValid, !cEmpty[mOwner]); end
        end
        expRead = xfer ? ownerHot : '0;
        tests++; if (cRead !== expRead) begin fails++; $display("FAIL rnd_read: got %b want %b", cRead, expRead); end
        if (xfer) begin
          tests++; if (cGrant !== ownerHot) begin fails++; $display("FAIL rnd_grant: got %b want %b", cGrant, ownerHot); end
          tests++; if (cData !== cFifoData[16*mOwner +: 16]) begin
            fails++; $display("FAIL rnd_data: got %h want %h", cData, cFifoData[16*mOwner +: 16]); end
          tests++; if (cDone !== (mCount == PL - 1)) begin
            fails++; $display("FAIL rnd_done: got %b want %b at word %0d", cDone, (mCount == PL - 1), mCount); end
          mCount++;
          if (mCount == PL) inPkt = 0;
        end else begin
          tests++; if (cDone !== 1'b0) begin fails++; $display("FAIL rnd_done_idle: got %b want 0", cDone); end
        end
        if (cErr !== 1'b0) bad++;
        finished = !inPkt;
        for (int k = 0; k < N; k++) if (q[k].size() != 0) finished = 0;
      end
      stallMask = '0;
      tests++; if (!finished) begin fails++; $display("FAIL rnd_timeout: got undrained FIFOs want all drained"); end
      tests++; if (bad !== 0) begin fails++; $display("FAIL rnd_hdrerr: got %0d cycles set want 0", bad); end
      tick(); tick(); tick();
      tests++; if (cGrant !== '0) begin fails++; $display("FAIL rnd_final_grant: got %b want 0000", cGrant); end
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      fifoEmpty[k] = 1'b1;
      fifoData[16*k +: 16] = 16'h0000;
    end
    @(negedge clk);
    test_reset();
    test_single_ch0();
    test_round_robin();
    test_ready_toggle();
    test_stall();
    test_header_err();
    test_reset_mid();
    test_random(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion want finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
